// File: rtl/uart_rx_if.sv
// Parallel-side handshake bundle of the UART receiver: held word, its status flags, and the pop strobe.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversampled frame recovery with parity/stop checks into a one-word valid/ready holding register.
// Latency: word valid one clock after the final stop-bit sample (8N1: 9.5 bit periods + 4 clocks from the start edge).
// Backpressure: rts = !rx_valid; a frame completing into a full register is dropped with a one-cycle overrun_err.
// Optional: define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling around each sample point.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 1,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       rx_in,
    uart_rx_if.master  rx_if,
    output logic       overrun_err,
    output logic       rx_busy,
    output logic       rts
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int START_PT = OVERSAMPLE / 2 + 1;
`else
    localparam int START_PT = OVERSAMPLE / 2 - 1;
`endif
    localparam logic [SW-1:0] START_LAST = SW'(START_PT);
    localparam logic [SW-1:0] BIT_LAST   = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rx_s, rx_s_d;
    logic [SW-1:0]        scnt;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_q, ferr_q;
    logic                 smp, fall, start_tick, bit_tick, par_bad, ferr_fin;
    logic                 scnt_clr, frame_clr, shift_en, par_ld, stop_ld, done;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, perr_o, ferr_o, pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Votes over rx_s on this tick and the two before it, so the decision tick is point+1.
    logic [1:0] vote_q;
    always_ff @(posedge clk) begin
        if (rst)       vote_q <= 2'b11;
        else if (tick) vote_q <= {vote_q[0], rx_s};
    end
    assign smp = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s) | (vote_q[0] & rx_s);
`else
    assign smp = rx_s;
`endif

    assign fall       = rx_s_d & ~rx_s;
    assign start_tick = tick && (scnt == START_LAST);
    assign bit_tick   = tick && (scnt == BIT_LAST);
    assign par_bad    = (PARITY_TYPE == 0) ? ^{shreg, smp} : ~^{shreg, smp};
    // With one stop bit the frame completes on the same tick the stop bit is judged.
    assign ferr_fin   = (state == STOP1) ? ~smp : ferr_q;

    always_comb begin
        state_nxt = state;
        scnt_clr  = 1'b0;
        frame_clr = 1'b0;
        shift_en  = 1'b0;
        par_ld    = 1'b0;
        stop_ld   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (fall) begin
                scnt_clr  = 1'b1;
                state_nxt = START;
            end
            START: if (start_tick) begin
                if (!smp) begin
                    scnt_clr  = 1'b1;
                    frame_clr = 1'b1;
                    state_nxt = DATA;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DATA: if (bit_tick) begin
                scnt_clr = 1'b1;
                shift_en = 1'b1;
                if (bcnt == BW'(DATA_BITS - 1))
                    state_nxt = (PARITY_EN != 0) ? PARITY : STOP1;
            end
            PARITY: if (bit_tick) begin
                scnt_clr  = 1'b1;
                par_ld    = 1'b1;
                state_nxt = STOP1;
            end
            STOP1: if (bit_tick) begin
                scnt_clr = 1'b1;
                stop_ld  = 1'b1;
                if (STOP_BITS == 2) begin
                    state_nxt = STOP2;
                end else begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            STOP2: if (bit_tick) begin
                scnt_clr  = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scnt   <= '0;
            bcnt   <= '0;
            shreg  <= '0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (scnt_clr)  scnt <= '0;
            else if (tick) scnt <= scnt + SW'(1);
            if (frame_clr) begin
                bcnt   <= '0;
                perr_q <= 1'b0;
                ferr_q <= 1'b0;
            end
            if (shift_en) begin
                shreg <= {smp, shreg[DATA_BITS-1:1]};
                bcnt  <= bcnt + BW'(1);
            end
            if (par_ld)  perr_q <= par_bad;
            if (stop_ld) ferr_q <= ~smp;
        end
    end

    assign pop = valid_q & rx_if.rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_o      <= 1'b0;
            ferr_o      <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (done) begin
                if (!valid_q || pop) begin
                    data_q  <= shreg;
                    perr_o  <= perr_q;
                    ferr_o  <= ferr_fin;
                    valid_q <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (pop) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data    = data_q;
    assign rx_if.rx_valid   = valid_q;
    assign rx_if.parity_err = perr_o;
    assign rx_if.frame_err  = ferr_o;
    assign rx_busy          = (state != IDLE);
    assign rts              = ~valid_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx in 8E1 / OVERSAMPLE=16 with tick every 4 clocks (64 clocks per bit), scoreboard-checked.
module tb_uart_rx;
    localparam int BIT = 64;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic rx_in = 1'b1;
    logic overrun_err, rx_busy, rts;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_ovr = 0;
    int   tcnt = 0;
    exp_t sb[$];
    exp_t mon_e;

    uart_rx_if #(.DATA_BITS(8)) rxif ();

    uart_rx #(
        .DATA_BITS(8), .PARITY_EN(1), .PARITY_TYPE(0), .STOP_BITS(1), .OVERSAMPLE(16)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .rx_in(rx_in), .rx_if(rxif),
        .overrun_err(overrun_err), .rx_busy(rx_busy), .rts(rts)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tcnt = (tcnt + 1) % 4;
            tick = (tcnt == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every handshake pops one expected word.
    always @(negedge clk) begin
        if (!rst && rxif.rx_valid && rxif.rx_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_word", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rx_data", 32'(rxif.rx_data), 32'(mon_e.d));
                chk("parity_err", 32'(rxif.parity_err), 32'(mon_e.pe));
                chk("frame_err", 32'(rxif.frame_err), 32'(mon_e.fe));
            end
        end
        if (overrun_err) n_ovr++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input logic glitch);
        rx_in = b;
        if (glitch) begin
            cyc(BIT / 2 - 2);
            rx_in = ~b;
            cyc(4);
            rx_in = b;
            cyc(BIT / 2 - 2);
        end else begin
            cyc(BIT);
        end
    endtask

    // abort_bit >= 0 stops halfway through that data bit and leaves the line there.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stp,
                              input int glitch_bit, input int abort_bit);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (abort_bit == i) begin
                rx_in = d[i];
                cyc(BIT / 2);
                return;
            end
            drive_bit(d[i], glitch_bit == i);
        end
        drive_bit(p, 1'b0);
        drive_bit(stp, 1'b0);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic p, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = (^d) ^ p;
        e.fe = fe;
        sb.push_back(e);
    endtask

    task automatic frame(input logic [7:0] d, input logic p);
        send_frame(d, p, 1'b1, -1, -1);
        rx_in = 1'b1;
        cyc(BIT);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!rxif.rx_valid && k < 4 * BIT) begin
            cyc(1);
            k++;
        end
        chk(tag, 32'(rxif.rx_valid), 32'd1);
    endtask

    task automatic pop_word();
        rxif.rx_ready = 1'b1;
        cyc(1);
        rxif.rx_ready = 1'b0;
        cyc(1);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_rx_valid"}, 32'(rxif.rx_valid), 32'd0);
        chk({pfx, "_rx_data"}, 32'(rxif.rx_data), 32'd0);
        chk({pfx, "_parity_err"}, 32'(rxif.parity_err), 32'd0);
        chk({pfx, "_frame_err"}, 32'(rxif.frame_err), 32'd0);
        chk({pfx, "_overrun_err"}, 32'(overrun_err), 32'd0);
        chk({pfx, "_rx_busy"}, 32'(rx_busy), 32'd0);
        chk({pfx, "_rts"}, 32'(rts), 32'd1);
    endtask

    initial begin
        rxif.rx_ready = 1'b0;
        cyc(4);
        rst = 1'b0;
        cyc(2);
        chk_reset_vals("reset");

        // Clean 8E1 frame held until popped.
        push_exp(8'hA5, 1'b0, 1'b0);
        frame(8'hA5, 1'b0);
        wait_valid("a5_valid");
        chk("a5_rts_low", 32'(rts), 32'd0);
        cyc(BIT);
        chk("a5_still_held", 32'(rxif.rx_valid), 32'd1);
        pop_word();
        chk("a5_popped_rts", 32'(rts), 32'd1);

        // Parity error then good parity.
        push_exp(8'h3C, 1'b1, 1'b0);
        frame(8'h3C, 1'b1);
        wait_valid("3c_bad_valid");
        pop_word();
        push_exp(8'h3C, 1'b0, 1'b0);
        frame(8'h3C, 1'b0);
        wait_valid("3c_good_valid");
        pop_word();

        // Framing error, then a long low line that must not retrigger.
        push_exp(8'h55, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b0, -1, -1);
        wait_valid("55_valid");
        pop_word();
        cyc(20 * BIT);
        chk("low_line_busy", 32'(rx_busy), 32'd0);
        chk("low_line_valid", 32'(rxif.rx_valid), 32'd0);
        rx_in = 1'b1;
        cyc(2 * BIT);
        push_exp(8'h12, 1'b0, 1'b0);
        frame(8'h12, 1'b0);
        wait_valid("12_valid");
        pop_word();

        // Overrun: second word dropped, held word untouched.
        n_ovr = 0;
        push_exp(8'h11, 1'b0, 1'b0);
        frame(8'h11, 1'b0);
        wait_valid("11_valid");
        frame(8'h22, 1'b0);
        chk("overrun_pulses", 32'(n_ovr), 32'd1);
        chk("overrun_held_data", 32'(rxif.rx_data), 32'h11);
        pop_word();
        push_exp(8'h33, 1'b0, 1'b0);
        frame(8'h33, 1'b0);
        wait_valid("33_valid");
        pop_word();
        chk("overrun_total", 32'(n_ovr), 32'd1);

        // Three-tick low glitch is a false start.
        rx_in = 1'b0;
        cyc(8);
        chk("glitch_busy", 32'(rx_busy), 32'd1);
        cyc(4);
        rx_in = 1'b1;
        cyc(2 * BIT);
        chk("glitch_idle", 32'(rx_busy), 32'd0);
        chk("glitch_no_valid", 32'(rxif.rx_valid), 32'd0);

`ifdef UART_RX_MAJORITY_VOTE_EN
        push_exp(8'hF0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 5, -1);
        rx_in = 1'b1;
        cyc(BIT);
        wait_valid("vote_valid");
        pop_word();
`endif

        // Reset during data bit 4 of 0x81.
        send_frame(8'h81, 1'b0, 1'b1, -1, 4);
        chk("midframe_busy", 32'(rx_busy), 32'd1);
        rst = 1'b1;
        rx_in = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk_reset_vals("midrst");
        cyc(2 * BIT);
        chk("midrst_no_valid", 32'(rxif.rx_valid), 32'd0);
        push_exp(8'h7E, 1'b0, 1'b0);
        frame(8'h7E, 1'b0);
        wait_valid("7e_valid");
        pop_word();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver paired with the existing transmitter: it recovers frames from the `rx_in` line using an oversampling tick, checks parity and stop bits, and presents each received byte on a valid/ready holding register. It sits between the pad-side serial input and the parallel consumer (FIFO or register interface), and drives `rts` so that a far-end transmitter with CTS flow control can be throttled.

## Interface
- `DATA_BITS`, 8: data bits per frame; range 5–9; sent LSB first.
- `PARITY_EN`, 1: 1 means a parity bit follows the data.
- `PARITY_TYPE`, 0: 0 means even parity, 1 means odd parity.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `OVERSAMPLE`, 16: `tick` pulses per bit period; must be even and at least 8.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `tick` in 1: single-cycle oversample strobe at `OVERSAMPLE` × baud.
- `rx_in` in 1: asynchronous serial input; the line idles high.
- `rx_ready` in 1: consumer accepts `rx_data`.
- `rx_data` out `DATA_BITS`: received data word.
- `rx_valid` out 1: the holding register is full.
- `parity_err` out 1: parity mismatch for the word held in `rx_data`; valid while `rx_valid` is high.
- `frame_err` out 1: the first stop bit was sampled low for the held word; valid while `rx_valid` is high.
- `overrun_err` out 1: one-cycle pulse when a frame is dropped because the holding register is full.
- `rx_busy` out 1: high whenever the FSM is not in IDLE.
- `rts` out 1: ready to send; equals `!rx_valid`.

## Operation
- **Synchronizer.** `rx_in` passes through a 2-flop synchronizer, which resets to 1. The FSM samples only the synchronized value `rx_s`. An edge detector flop `rx_s_d` also resets to 1.
- **Sample counter.** `scnt` is a sample counter of width `$clog2(OVERSAMPLE)`. It advances only on `tick`.
- **FSM states.** IDLE, START, DATA, PARITY, STOP1, STOP2.
- **IDLE.** A 1→0 transition on `rx_s` clears `scnt` and moves to START. A line held low never re-triggers the FSM.
- **START.** On the tick where `scnt == OVERSAMPLE/2-1`, the sampled value is checked:
  - 0: clear `scnt`, clear `bcnt`, go to DATA.
  - 1: false start; return to IDLE without any flag.
- **DATA.** On the tick where `scnt == OVERSAMPLE-1`, the sampled bit shifts in at the MSB (right shift, LSB first). When `bcnt == DATA_BITS-1`, go to PARITY if `PARITY_EN`, else STOP1. Otherwise increment `bcnt`.
- **PARITY.** Sampled at `scnt == OVERSAMPLE-1`. The parity error is set as follows:
  - even parity: error = `^{data, p}`;
  - odd parity: error = `~^{data, p}`.
- **STOP1.** Sampled at `scnt == OVERSAMPLE-1`; a sample of 0 sets the frame error.
  - If `STOP_BITS == 2`, go to STOP2.
  - Otherwise the frame completes.
- **STOP2.** Sampled the same way. The frame completes regardless of the value; only the first stop bit affects `frame_err`.
- **Frame completion.** The FSM returns to IDLE. Then:
  - If `rx_valid` is 0: load `rx_data`, `parity_err` and `frame_err`, and set `rx_valid`.
  - If `rx_valid` is 1: discard the new frame, pulse `overrun_err` for one cycle, and leave the held word untouched.
- **Handshake.** `rx_valid` clears on a cycle where `rx_valid && rx_ready`.
  - If a completion and a pop occur in the same cycle, the new word loads, `rx_valid` stays 1, and no overrun is flagged.
- **Reset mid-frame.** The FSM returns to IDLE and any partial frame is discarded.
- **Reset values.** `rx_data` = 0, `rx_valid` = 0, `parity_err` = 0, `frame_err` = 0, `overrun_err` = 0, `rx_busy` = 0, `rts` = 1.

## Timing
- **Input latency.** A `rx_in` change reaches `rx_s` after 2 clocks, and the start edge is detected 1 clock later.
- **Sample points.** Bit sampling happens at the tick OVERSAMPLE/2 ticks after the start edge, then every OVERSAMPLE ticks.
- **Completion.** `rx_valid` rises on the clock after the final stop-bit sample tick. For 8N1, that is 9.5 bit periods plus 4 clocks after the falling edge of `rx_in`.
- **RTS.** `rts` follows `rx_valid` combinationally (inverted), with no added latency.
- **No tick.** If `tick` never asserts, the FSM holds its state indefinitely.

## Configuration
- **With `UART_RX_MAJORITY_VOTE_EN` defined:** each sample point (start, data, parity and stop) uses a 2-of-3 majority of `rx_s` captured on the ticks at `scnt` = point-1, point and point+1.
  - For the mid-start sample, the START state still decides at `scnt == OVERSAMPLE/2+1`.
  - Every subsequent sample point is shifted by the same +1 tick.
- **Without the macro:** a single `rx_s` sample is taken at the sample tick, and no vote registers exist.

## Test plan
- **Clean 8E1 frame.** `tick` every 4 clocks, OVERSAMPLE=16, frame 0xA5 sent with even parity bit 0 → `rx_data`=0xA5, `rx_valid`=1, `parity_err`=0, `frame_err`=0, `rts`=0 until `rx_ready` pops it.
- **Parity error.** 0x3C sent with parity bit 1 (even config) → `rx_data`=0x3C, `parity_err`=1. Next frame 0x3C with parity bit 0 → `parity_err`=0.
- **Framing error.** 0x55 sent with stop bit 0 → `frame_err`=1. The line is then held low for 20 bit periods with no new frame; after the line returns high, a clean frame 0x12 is received correctly.
- **Overrun.** 0x11 received with `rx_ready`=0, then 0x22 received → `overrun_err` pulses one cycle and `rx_data` stays 0x11. Pop, then 0x33 → `rx_data`=0x33.
- **False start and glitch rejection.**
  - A 3-tick low glitch on `rx_in` → FSM returns to IDLE and `rx_valid` stays 0.
  - With `UART_RX_MAJORITY_VOTE_EN` defined, a single-tick inversion at the mid-point of a data bit still yields the correct byte (0xF0).
- **Reset mid-frame.** `rst` is asserted during data bit 4 of 0x81 → all outputs return to their reset values, and the next clean frame 0x7E is received correctly.
